// File: rtl/stall_mgmt.sv
// stall_mgmt: pipeline stall / drain / flush controller driving global buffer controls.
// Define STALL_MGMT_STATS_EN to build the saturating STALL/DRAIN cycle counters.
module stall_mgmt #(
  parameter int NUM_STAGES   = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ext_stall,
  input  logic                  flush_req,
  input  logic [NUM_STAGES-1:0] buf_full,
  input  logic [NUM_STAGES-1:0] buf_empty,
  output logic                  stall,
  output logic                  flush,
  output logic                  upstream_hold,
  output logic [1:0]            state,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           drain_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e                state_p0;
  state_e                state_nxt;
  logic [3:0]            flush_cnt_p0;
  logic [3:0]            flush_cnt_nxt;
  logic [NUM_STAGES-1:0] full_p0;
  logic                  all_empty;

  // A stage flagged both full and empty counts as empty here and as full for upstream_hold.
  assign all_empty = &buf_empty;

  // Stage p0: state, flush countdown and one-cycle-old full flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0     <= RUN;
      flush_cnt_p0 <= '0;
      full_p0      <= '0;
    end else begin
      state_p0     <= state_nxt;
      flush_cnt_p0 <= flush_cnt_nxt;
      full_p0      <= buf_full;
    end
  end

  always_comb begin
    state_nxt     = state_p0;
    flush_cnt_nxt = flush_cnt_p0;
    if (flush_req) begin
      state_nxt     = FLUSH;
      flush_cnt_nxt = FLUSH_LOAD;
    end else begin
      case (state_p0)
        RUN: begin
          if (ext_stall) state_nxt = STALL;
        end
        STALL: begin
          if (!ext_stall) state_nxt = all_empty ? RUN : DRAIN;
        end
        DRAIN: begin
          if (ext_stall)      state_nxt = STALL;
          else if (all_empty) state_nxt = RUN;
        end
        FLUSH: begin
          // Last flush cycle when the countdown is at one.
          if (flush_cnt_p0 <= 4'd1) begin
            flush_cnt_nxt = '0;
            state_nxt     = ext_stall ? STALL : RUN;
          end else begin
            flush_cnt_nxt = flush_cnt_p0 - 4'd1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    state         = state_p0;
    stall         = (state_p0 == STALL);
    flush         = (state_p0 == FLUSH);
    upstream_hold = (state_p0 == DRAIN) || (state_p0 == FLUSH) ||
                    ((state_p0 == STALL) && (|full_p0));
  end

`ifdef STALL_MGMT_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] stall_cnt_p1;
  logic [15:0] drain_cnt_p1;

  // Stage p1: residency counters, untouched by flush
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_p1 <= '0;
      drain_cnt_p1 <= '0;
    end else begin
      if (state_p0 == STALL) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
      if (state_p0 == DRAIN) drain_cnt_p1 <= sat_inc(drain_cnt_p1);
    end
  end

  assign stall_cycles = stall_cnt_p1;
  assign drain_cycles = drain_cnt_p1;
`else
  assign stall_cycles = 16'd0;
  assign drain_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_stall_mgmt.sv
// tb_stall_mgmt: directed and random stimulus for stall_mgmt against a behavioural model.
module tb_stall_mgmt;
  localparam int NS = 4;
  localparam int FC = 2;
  localparam int S_RUN = 0, S_STALL = 1, S_DRAIN = 2, S_FLUSH = 3;
`ifdef STALL_MGMT_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          ext_stall;
  logic          flush_req;
  logic [NS-1:0] buf_full;
  logic [NS-1:0] buf_empty;
  logic          stall;
  logic          flush;
  logic          upstream_hold;
  logic [1:0]    state;
  logic [15:0]   stall_cycles;
  logic [15:0]   drain_cycles;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: current mode, flush cycles still to serve, last sampled full flags.
  int            m_state;
  int            m_left;
  int            m_stall_cnt;
  int            m_drain_cnt;
  logic [NS-1:0] m_full_prev;
  int            d0;

  stall_mgmt #(.NUM_STAGES(NS), .FLUSH_CYCLES(FC)) dut (
    .clk           (clk),
    .reset         (reset),
    .ext_stall     (ext_stall),
    .flush_req     (flush_req),
    .buf_full      (buf_full),
    .buf_empty     (buf_empty),
    .stall         (stall),
    .flush         (flush),
    .upstream_hold (upstream_hold),
    .state         (state),
    .stall_cycles  (stall_cycles),
    .drain_cycles  (drain_cycles)
  );

  always #5 clk = ~clk;

  function automatic int exp_stat(input int c);
    return STATS_EN ? c : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state     = S_RUN;
    m_left      = 0;
    m_stall_cnt = 0;
    m_drain_cnt = 0;
    m_full_prev = '0;
  endtask

  task automatic model_edge();
    bit every_empty;
    int cur;
    every_empty = (buf_empty == {NS{1'b1}});
    cur = m_state;
    if (cur == S_STALL && m_stall_cnt < 65535) m_stall_cnt++;
    if (cur == S_DRAIN && m_drain_cnt < 65535) m_drain_cnt++;
    if (flush_req) begin
      m_state = S_FLUSH;
      m_left  = FC;
    end else if (cur == S_RUN) begin
      m_state = ext_stall ? S_STALL : S_RUN;
    end else if (cur == S_STALL) begin
      if (!ext_stall) m_state = every_empty ? S_RUN : S_DRAIN;
    end else if (cur == S_DRAIN) begin
      if (ext_stall) m_state = S_STALL;
      else if (every_empty) m_state = S_RUN;
    end else begin
      m_left = m_left - 1;
      if (m_left == 0) m_state = ext_stall ? S_STALL : S_RUN;
    end
    m_full_prev = buf_full;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".state"}, state, m_state);
    check({tag, ".stall"}, stall, m_state == S_STALL);
    check({tag, ".flush"}, flush, m_state == S_FLUSH);
    check({tag, ".hold"}, upstream_hold, (m_state == S_DRAIN) || (m_state == S_FLUSH) ||
                                         ((m_state == S_STALL) && (m_full_prev != 0)));
    check({tag, ".stall_cycles"}, stall_cycles, exp_stat(m_stall_cnt));
    check({tag, ".drain_cycles"}, drain_cycles, exp_stat(m_drain_cnt));
  endtask

  task automatic step(input string tag, input bit do_check);
    @(posedge clk);
    model_edge();
    #1;
    if (do_check) check_outputs(tag);
  endtask

  initial begin
    reset     = 1'b0;
    ext_stall = 1'b0;
    flush_req = 1'b0;
    buf_full  = '0;
    buf_empty = '1;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;

    // Idle after reset release
    for (int i = 0; i < 10; i++) step("idle", 1'b1);

    // Stall with a full stage, then drain
    for (int i = 0; i < 5; i++) begin
      ext_stall = 1'b1;
      buf_full  = (i >= 1) ? 4'b0100 : 4'b0000;
      step("stall5", 1'b1);
      check("stall5.stall_direct", stall, 1'b1);
    end
    ext_stall = 1'b0;
    buf_empty = 4'hB;
    for (int i = 0; i < 3; i++) begin
      step("drain3", 1'b1);
      check("drain3.state_direct", state, 2'd2);
    end
    buf_empty = 4'hF;
    buf_full  = '0;
    step("drain_exit", 1'b1);
    check("drain_exit.state_direct", state, 2'd0);
    check("drain_exit.stall_cycles_direct", stall_cycles, exp_stat(5));
    check("drain_exit.drain_cycles_direct", drain_cycles, exp_stat(3));

    // Single flush pulse during STALL, ext_stall held then dropped
    for (int pass = 0; pass < 2; pass++) begin
      ext_stall = 1'b1;
      step("fl1_pre", 1'b1);
      flush_req = 1'b1;
      step("fl1_a", 1'b1);
      check("fl1_a.flush_direct", {flush, stall}, 2'b10);
      flush_req = 1'b0;
      if (pass == 1) ext_stall = 1'b0;
      step("fl1_b", 1'b1);
      check("fl1_b.flush_direct", {flush, stall}, 2'b10);
      step("fl1_exit", 1'b1);
      check("fl1_exit.state_direct", state, (pass == 0) ? 2'd1 : 2'd0);
    end

    // Back-to-back flush requests extend the flush
    flush_req = 1'b1;
    step("fl2_a", 1'b1);
    step("fl2_b", 1'b1);
    flush_req = 1'b0;
    step("fl2_c", 1'b1);
    check("fl2_c.flush_hold_direct", {flush, upstream_hold}, 2'b11);
    step("fl2_exit", 1'b1);
    check("fl2_exit.flush_direct", flush, 1'b0);

    // ext_stall returns on the second DRAIN cycle
    ext_stall = 1'b1;
    step("rs_stall", 1'b1);
    d0 = m_drain_cnt;
    ext_stall = 1'b0;
    buf_empty = 4'h7;
    step("rs_d1", 1'b1);
    step("rs_d2", 1'b1);
    ext_stall = 1'b1;
    step("rs_back", 1'b1);
    check("rs_back.stall_direct", {stall, state}, {1'b1, 2'd1});
    check("rs_back.drain_inc", drain_cycles, exp_stat(d0 + 2));
    ext_stall = 1'b0;
    buf_empty = 4'hF;
    step("rs_end", 1'b1);

    // Random traffic, including illegal full+empty stages
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ext_stall = ~ext_stall;
      flush_req = ($urandom_range(0, 19) == 0);
      buf_full  = 4'($urandom);
      buf_empty = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
      step("rand", 1'b1);
    end

    // Asynchronous reset in the middle of a flush
    ext_stall = 1'b0;
    buf_empty = 4'hF;
    buf_full  = '0;
    flush_req = 1'b1;
    step("rf_flush", 1'b1);
    flush_req = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rf.flush_direct", flush, 1'b0);
    check("rf.state_direct", state, 2'd0);
    check_outputs("rf");
    @(negedge clk);
    reset = 1'b1;
    step("rf_release", 1'b1);

    // Long STALL: counter saturates when built, stays zero otherwise
    ext_stall = 1'b1;
    for (int i = 0; i < 70000; i++) step("long", (i % 5000) == 0);
    check_outputs("long_end");
    check("long_end.stall_cycles_direct", stall_cycles, STATS_EN ? 16'hFFFF : 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
